// File: rtl/softmax_ru_seq_if.sv
// softmax_ru_seq_if: input stream, RU, log2 and output stream signals of the softmax sequencer
interface softmax_ru_seq_if #(
   parameter int DW = 16,
   parameter int AW = 19
);
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          ru_en;
   logic          ru_valid_in;
   logic [DW-1:0] ru_in_0;
   logic [DW-1:0] ru_in_1;
   logic          ru_sel_mult;
   logic          ru_sel_mux;
   logic          ru_valid_out;
   logic [DW-1:0] ru_out_0;
   logic [DW-1:0] ru_out_1;
   logic          log_req;
   logic [AW-1:0] log_sum;
   logic          log_ack;
   logic [DW-1:0] log_res;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          busy;
   modport master (
      input  start, in_valid, in_data, ru_valid_out, ru_out_0, ru_out_1, log_ack, log_res, out_ready,
      output in_ready, ru_en, ru_valid_in, ru_in_0, ru_in_1, ru_sel_mult, ru_sel_mux,
             log_req, log_sum, out_valid, out_data, busy
   );
   modport slave (
      output start, in_valid, in_data, ru_valid_out, ru_out_0, ru_out_1, log_ack, log_res, out_ready,
      input  in_ready, ru_en, ru_valid_in, ru_in_0, ru_in_1, ru_sel_mult, ru_sel_mux,
             log_req, log_sum, out_valid, out_data, busy
   );
endinterface

// File: rtl/softmax_ru_seq.sv
// softmax_ru_seq: runs one N-element Q8.8 softmax vector through the shared RU and an external log2 unit
module softmax_ru_seq #(
   parameter int N  = 8,
   parameter int DW = 16,
   parameter int AW = DW + $clog2(N)
) (
   input logic             clk,
   input logic             rst,
   softmax_ru_seq_if.master bus
);
   localparam int IW = $clog2(N);
   typedef enum logic [2:0] {IDLE, LOAD, S1_ISSUE, S1_WAIT, LOG, S2_ISSUE, S2_WAIT, S2_OUT} state_t;
   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic [DW-1:0] max_v, lsum, out_q;
   logic [AW-1:0] sum;
   logic [DW-1:0] x_buf [N];
   logic [DW-1:0] y_buf [N];
   logic          last, beat, s1, s2, s1_done, s2_done, log_done, out_done;
   assign last     = idx == IW'(N - 1);
   assign beat     = state == LOAD && bus.in_valid;
   assign s1       = state == S1_ISSUE || state == S1_WAIT;
   assign s2       = state == S2_ISSUE || state == S2_WAIT;
   assign s1_done  = state == S1_WAIT && bus.ru_valid_out;
   assign s2_done  = state == S2_WAIT && bus.ru_valid_out;
   assign log_done = state == LOG && bus.log_ack;
   assign out_done = state == S2_OUT && bus.out_ready;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = bus.start ? LOAD : IDLE;
         LOAD:     state_nx = beat && last ? S1_ISSUE : LOAD;
         S1_ISSUE: state_nx = S1_WAIT;
         S1_WAIT:  state_nx = s1_done ? (last ? LOG : S1_ISSUE) : S1_WAIT;
         LOG:      state_nx = log_done ? S2_ISSUE : LOG;
         S2_ISSUE: state_nx = S2_WAIT;
         S2_WAIT:  state_nx = s2_done ? S2_OUT : S2_WAIT;
         S2_OUT:   state_nx = out_done ? (last ? IDLE : S2_ISSUE) : S2_OUT;
         default:  state_nx = IDLE;
      endcase
   end
   // idx wraps to 0 after the last element since N is a power of 2
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         idx   <= '0;
         max_v <= '0;
         sum   <= '0;
         lsum  <= '0;
         out_q <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            idx <= '0;
            sum <= '0;
         end
         if (beat) begin
            max_v <= (idx == '0 || $signed(bus.in_data) > $signed(max_v)) ? bus.in_data : max_v;
            idx   <= idx + 1'b1;
         end
         if (s1_done) begin
            sum <= sum + AW'(bus.ru_out_1);
            idx <= idx + 1'b1;
         end
         if (log_done) begin
            lsum <= bus.log_res;
            idx  <= '0;
         end
         if (s2_done) out_q <= bus.ru_out_1;
         if (out_done) idx <= idx + 1'b1;
      end
   always_ff @(posedge clk) begin
      if (beat) x_buf[idx] <= bus.in_data;
      if (s1_done) y_buf[idx] <= bus.ru_out_0;
   end
   assign bus.in_ready    = state == LOAD;
   assign bus.busy        = state != IDLE;
   assign bus.ru_en       = state != IDLE && state != LOAD;
   assign bus.ru_valid_in = state == S1_ISSUE || state == S2_ISSUE;
   assign bus.ru_in_0     = s1 ? max_v : s2 ? lsum : '0;
   assign bus.ru_in_1     = s1 ? x_buf[idx] : s2 ? y_buf[idx] : '0;
   assign bus.ru_sel_mult = s1;
   assign bus.ru_sel_mux  = s1;
   assign bus.log_req     = state == LOG;
   assign bus.log_sum     = state == LOG ? sum : '0;
   assign bus.out_valid   = state == S2_OUT;
   assign bus.out_data    = out_q;
endmodule

// File: tb/tb_softmax_ru_seq.sv
// tb_softmax_ru_seq: directed bench with a latency-3 RU model and a 2-cycle log2 stub
module tb_softmax_ru_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   softmax_ru_seq_if #(.DW(16), .AW(18)) bus ();
   softmax_ru_seq #(.N(4), .DW(16), .AW(18)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   logic [15:0] cur0, cur1;
   logic [1:0]  cnt;
   logic        rvo_m, stray, prev_vin;
   logic [1:0]  lcnt;
   logic        ack_q;
   int          op_cnt = 0, out_cnt = 0, overlap = 0, wide = 0, hold_err = 0;
   logic [15:0] op_in0 [64];
   logic [15:0] op_in1 [64];
   logic        op_sm  [64];
   logic        op_sx  [64];
   logic [15:0] out_log [64];
   logic [17:0] last_lsum;
   logic [15:0] vec [4];
   logic [15:0] ya  [4];
   logic [15:0] yn  [4];
   assign bus.ru_valid_out = rvo_m | stray;
   assign bus.ru_out_0     = cur1 - cur0;
   assign bus.ru_out_1     = 16'h0080;
   assign bus.log_ack      = ack_q;
   assign bus.log_res      = 16'h0100;
   always @(posedge clk or negedge rst)
      if (!rst) begin
         cnt   <= 2'd0;
         rvo_m <= 1'b0;
         lcnt  <= 2'd0;
         ack_q <= 1'b0;
      end else begin
         rvo_m <= cnt == 2'd1;
         if (bus.ru_valid_in) begin
            cnt  <= 2'd3;
            cur0 <= bus.ru_in_0;
            cur1 <= bus.ru_in_1;
         end else if (cnt != 2'd0) cnt <= cnt - 2'd1;
         ack_q <= bus.log_req && !ack_q && lcnt == 2'd1;
         lcnt  <= (bus.log_req && !ack_q) ? lcnt + 2'd1 : 2'd0;
      end
   always @(posedge clk) begin
      if (bus.ru_valid_in) begin
         if (cnt != 2'd0 || rvo_m) overlap++;
         if (prev_vin) wide++;
         op_in0[op_cnt % 64] = bus.ru_in_0;
         op_in1[op_cnt % 64] = bus.ru_in_1;
         op_sm[op_cnt % 64]  = bus.ru_sel_mult;
         op_sx[op_cnt % 64]  = bus.ru_sel_mux;
         op_cnt++;
      end else if (rst && (cnt != 2'd0 || rvo_m) && (bus.ru_in_0 !== cur0 || bus.ru_in_1 !== cur1)) hold_err++;
      prev_vin = bus.ru_valid_in;
      if (bus.out_valid && bus.out_ready) begin
         out_log[out_cnt % 64] = bus.out_data;
         out_cnt++;
      end
      if (bus.log_req && bus.log_ack) last_lsum = bus.log_sum;
   end
   function automatic logic [73:0] all_outs();
      return {bus.in_ready, bus.ru_en, bus.ru_valid_in, bus.ru_in_0, bus.ru_in_1, bus.ru_sel_mult,
              bus.ru_sel_mux, bus.log_req, bus.log_sum, bus.out_valid, bus.out_data, bus.busy};
   endfunction
   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic send_beats();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vec[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      int t = 0;
      while (bus.busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy=%b required 0 (timeout)", name, bus.busy);
      end
   endtask
   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (all_outs() !== 74'd0) begin
         errors++;
         $display("FAIL reset_outs got %h required 0", all_outs());
      end
      rst = 1'b1;
   endtask
   task automatic test_stage1();
      int ob = op_cnt;
      int t = 0;
      vec = '{16'h0100, 16'h0240, 16'hFF00, 16'h0240};
      pulse_start();
      checks++;
      if ({bus.in_ready, bus.busy, bus.ru_en} !== 3'b110) begin
         errors++;
         $display("FAIL load_flags got %b required 110", {bus.in_ready, bus.busy, bus.ru_en});
      end
      send_beats();
      while (!bus.log_req && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (op_cnt - ob !== 4) begin
         errors++;
         $display("FAIL s1_ops got %0d required 4", op_cnt - ob);
      end
      checks++;
      if ({op_in0[ob], op_in1[ob], op_sm[ob], op_sx[ob]} !== {16'h0240, 16'h0100, 2'b11}) begin
         errors++;
         $display("FAIL s1_first got %h %h %b%b required 0240 0100 11", op_in0[ob], op_in1[ob], op_sm[ob], op_sx[ob]);
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if ({op_in0[ob+i], op_in1[ob+i], op_sm[ob+i], op_sx[ob+i]} !== {16'h0240, vec[i], 2'b11}) begin
            errors++;
            $display("FAIL s1_op%0d got %h %h required 0240 %h", i, op_in0[ob+i], op_in1[ob+i], vec[i]);
         end
      end
      checks++;
      if ({overlap, wide, hold_err} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL s1_protocol overlap=%0d wide=%0d hold=%0d required 0", overlap, wide, hold_err);
      end
   endtask
   task automatic test_log();
      int n = 0;
      logic ovl = 1'b0;
      while (bus.log_req && n < 20) begin
         checks++;
         if (bus.log_sum !== 18'h00200) begin
            errors++;
            $display("FAIL log_sum got %h required 00200", bus.log_sum);
         end
         if (bus.log_ack) ovl = 1'b1;
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 3 || !ovl) begin
         errors++;
         $display("FAIL log_hold cycles=%0d ack_seen=%b required 3 1", n, ovl);
      end
   endtask
   task automatic test_stage2();
      int ob = op_cnt;
      int oo = out_cnt;
      bus.out_ready = 1'b1;
      wait_idle("s2_done");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({op_in0[ob+i], op_in1[ob+i], op_sm[ob+i], op_sx[ob+i]} !== {16'h0100, ya[i], 2'b00}) begin
            errors++;
            $display("FAIL s2_op%0d got %h %h %b%b required 0100 %h 00", i, op_in0[ob+i], op_in1[ob+i], op_sm[ob+i], op_sx[ob+i], ya[i]);
         end
      end
      checks++;
      if (out_cnt - oo !== 4 || out_log[oo] !== 16'h0080 || out_log[oo+3] !== 16'h0080) begin
         errors++;
         $display("FAIL s2_outs count=%0d first=%h last=%h required 4 0080 0080", out_cnt - oo, out_log[oo], out_log[oo+3]);
      end
   endtask
   task automatic test_backpressure();
      int oo = out_cnt;
      int t;
      int n;
      logic [15:0] d;
      bus.out_ready = 1'b0;
      vec = '{16'h0100, 16'h0240, 16'hFF00, 16'h0240};
      pulse_start();
      send_beats();
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
         end
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid%0d got %b required 1", k, bus.out_valid);
         end
         if (k == 2) begin
            d = bus.out_data;
            n = op_cnt;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               checks++;
               if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h0080} || d !== 16'h0080) begin
                  errors++;
                  $display("FAIL bp_stall got %b %h required 1 0080", bus.out_valid, bus.out_data);
               end
            end
            checks++;
            if (op_cnt !== n) begin
               errors++;
               $display("FAIL bp_no_issue ops=%0d required %0d", op_cnt, n);
            end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop%0d out_valid=%b required 0", k, bus.out_valid);
         end
      end
      checks++;
      if (out_cnt - oo !== 4 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_done outs=%0d busy=%b required 4 0", out_cnt - oo, bus.busy);
      end
   endtask
   task automatic test_abuse();
      int ob = op_cnt;
      int oo = out_cnt;
      int t = 0;
      vec = '{16'h8000, 16'h8001, 16'hFFFF, 16'h8000};
      bus.out_ready = 1'b1;
      pulse_start();
      send_beats();
      while (!bus.ru_sel_mux && t < 100) begin
         @(negedge clk);
         t++;
      end
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      t = 0;
      while (!bus.log_req && t < 200) begin
         @(negedge clk);
         t++;
      end
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      t = 0;
      while (!(bus.ru_en && !bus.ru_sel_mux && !bus.log_req) && t < 100) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = i[0];
         bus.in_data  = 16'h1234;
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abuse_in_ready got %b required 0", bus.in_ready);
         end
      end
      bus.in_valid = 1'b0;
      wait_idle("abuse_done");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({op_in0[ob+i], op_in1[ob+i], op_in0[ob+4+i], op_in1[ob+4+i]} !== {16'hFFFF, vec[i], 16'h0100, yn[i]}) begin
            errors++;
            $display("FAIL abuse_op%0d got %h %h %h %h required ffff %h 0100 %h", i, op_in0[ob+i], op_in1[ob+i], op_in0[ob+4+i], op_in1[ob+4+i], vec[i], yn[i]);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (op_cnt - ob !== 8 || out_cnt - oo !== 4 || out_log[oo+1] !== 16'h0080 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL abuse_totals ops=%0d outs=%0d d=%h busy=%b required 8 4 0080 0", op_cnt - ob, out_cnt - oo, out_log[oo+1], bus.busy);
      end
   endtask
   task automatic test_reset_mid();
      int ob = op_cnt;
      int oo;
      int t = 0;
      int k = $urandom_range(1, 4);
      vec = '{16'h0100, 16'h0240, 16'hFF00, 16'h0240};
      bus.out_ready = 1'b1;
      pulse_start();
      send_beats();
      while (!(op_cnt - ob >= k && bus.ru_sel_mux && !bus.ru_valid_in) && t < 200) begin
         @(negedge clk);
         t++;
      end
      rst = 1'b0;
      #1;
      checks++;
      if (all_outs() !== 74'd0) begin
         errors++;
         $display("FAIL reset_mid got %h required 0", all_outs());
      end
      @(negedge clk);
      rst = 1'b1;
      ob = op_cnt;
      oo = out_cnt;
      pulse_start();
      send_beats();
      wait_idle("post_reset_done");
      checks++;
      if (op_cnt - ob !== 8 || out_cnt - oo !== 4 || last_lsum !== 18'h00200 || op_in1[ob+6] !== 16'hFCC0) begin
         errors++;
         $display("FAIL post_reset ops=%0d outs=%0d sum=%h y2=%h required 8 4 00200 fcc0", op_cnt - ob, out_cnt - oo, last_lsum, op_in1[ob+6]);
      end
   endtask
   initial begin
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      stray         = 1'b0;
      prev_vin      = 1'b0;
      ya = '{16'hFEC0, 16'h0000, 16'hFCC0, 16'h0000};
      yn = '{16'h8001, 16'h8002, 16'h0000, 16'h8001};
      test_reset();
      test_stage1();
      test_log();
      test_stage2();
      test_backpressure();
      test_abuse();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/softmax_ru_seq.md
Name: softmax_ru_seq

Overview:
- Sequencer that runs one N-element Q8.8 softmax vector through the shared RU datapath.
- Buffers the inputs and finds the running max.
- Issues stage-1 RU ops (x_i − max scaled by log2(e), then pow2) and accumulates the pow2 outputs into a sum.
- Hands the sum to an external log2 unit, then issues stage-2 RU ops and streams the N results out with backpressure.

Parameters:
- N, 8, vector length (power of 2, ≥2).
- DW, 16, Q8.8 data width.
- AW, DW+$clog2(N), sum accumulator width (Q(AW-8).8, unsigned).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  begin a new vector; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_data  in  DW  signed Q8.8 sample x_i.
- in_ready  out  1  high in LOAD.
- ru_en  out  1  RU enable.
- ru_valid_in  out  1  one-cycle op strobe to RU.
- ru_in_0  out  DW  RU operand 0.
- ru_in_1  out  DW  RU operand 1.
- ru_sel_mult  out  1  RU multiplier select.
- ru_sel_mux  out  1  RU mux select.
- ru_valid_out  in  1  RU result strobe.
- ru_out_0  in  DW  RU scaled difference.
- ru_out_1  in  DW  RU pow2 result.
- log_req  out  1  log2 request; held until acknowledged.
- log_sum  out  AW  accumulated pow2 sum.
- log_ack  in  1  log2 result valid.
- log_res  in  DW  signed Q8.8 log2(sum).
- out_valid  out  1  result valid.
- out_data  out  DW  softmax output.
- out_ready  in  1  consumer ready.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state=IDLE; all outputs 0, including ru_en, ru_valid_in, operands, selects, log_req, log_sum, out_valid, out_data and busy.
- Reset asserted mid-operation aborts the vector immediately. Buffers need not be cleared.
- States: IDLE → LOAD → S1_ISSUE ⇄ S1_WAIT → LOG → S2_ISSUE → S2_WAIT → S2_OUT → (S2_ISSUE | IDLE).
- IDLE: start=1 moves to LOAD; index=0, sum=0.
- LOAD:
  - in_ready=1; each in_valid&in_ready beat writes x_buf[index].
  - max := in_data on index 0; otherwise max := (signed in_data > max) ? in_data : max.
  - After the N-th beat go to S1_ISSUE with index=0.
- ru_en: 1 in all states from S1_ISSUE through S2_OUT; 0 in IDLE and LOAD.
- S1_ISSUE (one cycle):
  - ru_valid_in=1, ru_in_0=max, ru_in_1=x_buf[index], ru_sel_mux=1, ru_sel_mult=1.
  - Operands and selects hold until the matching ru_valid_out.
  - Go to S1_WAIT.
- S1_WAIT:
  - On ru_valid_out: y_buf[index] := ru_out_0; sum := sum + zero-extended ru_out_1 (no saturation; AW is sufficient by construction).
  - If index==N-1 go to LOG; else index++ and go to S1_ISSUE.
  - Exactly one RU op is outstanding at a time. RU latency is arbitrary (≥1 cycle).
  - ru_valid_out outside S1_WAIT/S2_WAIT is ignored.
- LOG:
  - log_req=1 and log_sum=sum, both held stable until log_ack.
  - On log_ack: lsum := log_res, log_req drops in the next cycle, index=0, go to S2_ISSUE.
- S2_ISSUE (one cycle):
  - ru_valid_in=1, ru_in_0=lsum, ru_in_1=y_buf[index], ru_sel_mux=0, ru_sel_mult=0.
  - Go to S2_WAIT.
- S2_WAIT: on ru_valid_out, out_data := ru_out_1, go to S2_OUT.
- S2_OUT:
  - out_valid=1; out_data stable until out_ready.
  - On out_valid&out_ready: if index==N-1 go to IDLE (busy drops the same edge); else index++ and go to S2_ISSUE.
  - out_valid deasserts the cycle after the handshake.
- Latency per element: stage 1 = 1 + L_ru cycles; stage 2 = 1 + L_ru + output stall.
- start while busy is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Simultaneous out_ready and state entry: the handshake completes no earlier than the first cycle of S2_OUT.

Test Plan:
- Bench uses a behavioural RU model with latency 3 that returns out_0=in_1−in_0 and out_1=0x0080, and a log2 stub with ack after 2 cycles returning 0x0100.
- Reset values: drive rst=0 at random mid-S1_WAIT → state IDLE, all outputs 0 within the same cycle; after release, start runs a clean vector.
- Max and stage-1 operands: N=4, inputs {0x0100, 0x0240, 0xFF00, 0x0240} → max=0x0240; first op ru_in_0=0x0240, ru_in_1=0x0100, sels=1/1, ru_valid_in one cycle wide; 4 ops, never 2 outstanding.
- Sum and log handshake: with out_1=0x0080 ×4 → log_sum=0x0200, log_req held across the 2-cycle ack delay, dropping after log_ack.
- Stage 2: ru_in_0=0x0100, sels=0/0, ru_in_1=y_buf in index order {0xFEC0, 0x0000, 0xFCC0, 0x0000}; 4 outputs of 0x0080.
- Backpressure: out_ready low for 5 cycles on result 2 → out_valid and out_data stable, no new RU op issued; all 4 results delivered, then busy=0.
- Protocol abuse: start pulsed during S1, in_valid toggled in S2, stray ru_valid_out in LOG → no effect on the sequence or results; all-negative inputs {0x8000, 0x8001, 0xFFFF, 0x8000} → max=0xFFFF.
